// File: rtl/srm_pkg.sv
// Shared encodings, FSM states and helper functions for the simple RISC core.
package srm_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned REG_N  = 8;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned IMM_W  = 8;

    // Top-level opcodes in bits [15:13]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // Sub-op codes in bits [12:11] under OPC_MOV
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_NOTB = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_t;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_EXEC      = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    // Instruction word layout; imm8 overlays {rd, sh, rm}
    typedef struct packed {
        logic [2:0]        opcode;
        logic [1:0]        op;
        logic [REG_AW-1:0] rn;
        logic [REG_AW-1:0] rd;
        logic [1:0]        sh;
        logic [REG_AW-1:0] rm;
    } instr_t;

    // One-bit barrel shift applied to the Rm operand
    function automatic logic [WORD_W-1:0] shift_word(input logic [WORD_W-1:0] x,
                                                     input shift_t            sh);
        logic [WORD_W-1:0] r;
        case (sh)
            SH_LSL:  r = {x[WORD_W-2:0], 1'b0};
            SH_LSR:  r = {1'b0, x[WORD_W-1:1]};
            SH_ASR:  r = {x[WORD_W-1], x[WORD_W-1:1]};
            default: r = x;
        endcase
        return r;
    endfunction

    // Sign-extend the 8-bit immediate to a full word
    function automatic logic [WORD_W-1:0] sign_extend_imm(input logic [IMM_W-1:0] imm);
        return {{(WORD_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/srm_datapath.sv
// Register file, operand registers, shifter, ALU, result register C and status flags.
module srm_datapath
    import srm_pkg::*;
(
    input  logic              clk,
    input  logic              write_imm,
    input  logic              write_reg,
    input  logic              load_a,
    input  logic              load_b,
    input  logic              load_c,
    input  logic              load_status,
    input  logic              a_zero,
    input  alu_op_t           alu_op,
    input  shift_t            sh,
    input  logic [REG_AW-1:0] rn,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] rm,
    input  logic [IMM_W-1:0]  imm8,
    output logic [WORD_W-1:0] c,
    output logic              n,
    output logic              v,
    output logic              z
);

    logic [WORD_W-1:0] regs [REG_N];
    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] b_q;
    logic [WORD_W-1:0] alu_a_c;
    logic [WORD_W-1:0] alu_b_c;
    logic [WORD_W-1:0] alu_res_c;

    // Register file write port: immediate goes to Rn, results go to Rd
    always_ff @(posedge clk) begin
        if (write_imm) begin
            regs[rn] <= sign_extend_imm(imm8);
        end else if (write_reg) begin
            regs[rd] <= c;
        end
    end

    // Operand capture from the combinational register-file read ports
    always_ff @(posedge clk) begin
        if (load_a) begin
            a_q <= regs[rn];
        end
        if (load_b) begin
            b_q <= regs[rm];
        end
    end

    // Shifter on B followed by the ALU; A is forced to zero for MOV/MVN
    always_comb begin
        alu_a_c   = a_zero ? '0 : a_q;
        alu_b_c   = shift_word(b_q, sh);
        alu_res_c = '0;
        case (alu_op)
            ALU_ADD:  alu_res_c = alu_a_c + alu_b_c;
            ALU_SUB:  alu_res_c = alu_a_c - alu_b_c;
            ALU_AND:  alu_res_c = alu_a_c & alu_b_c;
            ALU_NOTB: alu_res_c = ~alu_b_c;
            default:  alu_res_c = '0;
        endcase
    end

    // Result register C
    always_ff @(posedge clk) begin
        if (load_c) begin
            c <= alu_res_c;
        end
    end

    // Status flags from the compare subtraction
    always_ff @(posedge clk) begin
        if (load_status) begin
            n <= alu_res_c[WORD_W-1];
            z <= (alu_res_c == '0);
            v <= (alu_a_c[WORD_W-1] ^ alu_b_c[WORD_W-1]) &
                 (alu_res_c[WORD_W-1] ^ alu_a_c[WORD_W-1]);
        end
    end

endmodule

// File: rtl/simple_risc_cpu.sv
// Multi-cycle 16-bit execution core: instruction register, control FSM and datapath.
module simple_risc_cpu
    import srm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              load,
    input  logic [WORD_W-1:0] in,
    output logic [WORD_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic              w
);

    state_t state;
    instr_t ir_q;

    logic    is_mov_imm_c;
    logic    is_mov_reg_c;
    logic    is_alu_c;
    logic    is_cmp_c;
    logic    is_mvn_c;

    logic    write_imm_c;
    logic    write_reg_c;
    logic    load_a_c;
    logic    load_b_c;
    logic    load_c_c;
    logic    load_status_c;
    logic    a_zero_c;
    alu_op_t alu_op_c;

    // Instruction register, only writable while idle
    always_ff @(posedge clk) begin
        if (load && (state == S_WAIT)) begin
            ir_q <= instr_t'(in);
        end
    end

    // Instruction class decode from the held instruction
    always_comb begin
        is_mov_imm_c = (ir_q.opcode == OPC_MOV) && (ir_q.op == OP_MOV_IMM);
        is_mov_reg_c = (ir_q.opcode == OPC_MOV) && (ir_q.op == OP_MOV_REG);
        is_alu_c     = (ir_q.opcode == OPC_ALU);
        is_cmp_c     = is_alu_c && (ir_q.op == 2'(ALU_SUB));
        is_mvn_c     = is_alu_c && (ir_q.op == 2'(ALU_NOTB));
    end

    // Control FSM; w is registered alongside the state and is high exactly in Wait
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
            w     <= 1'b1;
        end else begin
            case (state)
                S_WAIT: begin
                    if (s) begin
                        state <= S_DECODE;
                        w     <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (is_mov_imm_c) begin
                        state <= S_WRITE_IMM;
                    end else if (is_mov_reg_c || is_alu_c) begin
                        state <= S_GET_A;
                    end else begin
                        state <= S_WAIT;
                        w     <= 1'b1;
                    end
                end
                S_WRITE_IMM: begin
                    state <= S_WAIT;
                    w     <= 1'b1;
                end
                S_GET_A: begin
                    state <= S_GET_B;
                end
                S_GET_B: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_cmp_c) begin
                        state <= S_WAIT;
                        w     <= 1'b1;
                    end else begin
                        state <= S_WRITE_REG;
                    end
                end
                S_WRITE_REG: begin
                    state <= S_WAIT;
                    w     <= 1'b1;
                end
                default: begin
                    state <= S_WAIT;
                    w     <= 1'b1;
                end
            endcase
        end
    end

    // Datapath strobes per state; a reset edge suppresses every write
    always_comb begin
        write_imm_c   = 1'b0;
        write_reg_c   = 1'b0;
        load_a_c      = 1'b0;
        load_b_c      = 1'b0;
        load_c_c      = 1'b0;
        load_status_c = 1'b0;
        if (!reset) begin
            case (state)
                S_WRITE_IMM: write_imm_c   = 1'b1;
                S_GET_A:     load_a_c      = 1'b1;
                S_GET_B:     load_b_c      = 1'b1;
                S_EXEC: begin
                    load_c_c      = ~is_cmp_c;
                    load_status_c = is_cmp_c;
                end
                S_WRITE_REG: write_reg_c   = 1'b1;
                default:     write_imm_c   = 1'b0;
            endcase
        end
    end

    // ALU operation select: MOV register is an add with A forced to zero
    always_comb begin
        a_zero_c = is_mov_reg_c || is_mvn_c;
        alu_op_c = is_mov_reg_c ? ALU_ADD : alu_op_t'(ir_q.op);
    end

    srm_datapath u_datapath (
        .clk         (clk),
        .write_imm   (write_imm_c),
        .write_reg   (write_reg_c),
        .load_a      (load_a_c),
        .load_b      (load_b_c),
        .load_c      (load_c_c),
        .load_status (load_status_c),
        .a_zero      (a_zero_c),
        .alu_op      (alu_op_c),
        .sh          (shift_t'(ir_q.sh)),
        .rn          (ir_q.rn),
        .rd          (ir_q.rd),
        .rm          (ir_q.rm),
        .imm8        ({ir_q.rd, ir_q.sh, ir_q.rm}),
        .c           (out),
        .n           (N),
        .v           (V),
        .z           (Z)
    );

endmodule

// File: tb/tb_simple_risc_cpu.sv
// Self-checking bench for simple_risc_cpu against an instruction-level reference model.
module tb_simple_risc_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic [15:0] out;
    logic        N;
    logic        V;
    logic        Z;
    logic        w;

    int passed = 0;
    int total  = 0;

    // Architectural reference state
    logic [15:0] ref_r [8];
    logic [15:0] ref_c;
    logic        ref_n;
    logic        ref_v;
    logic        ref_z;

    simple_risc_cpu dut (
        .clk   (clk),
        .reset (reset),
        .s     (s),
        .load  (load),
        .in    (in),
        .out   (out),
        .N     (N),
        .V     (V),
        .Z     (Z),
        .w     (w)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [2:0] opc, input logic [1:0] op,
                                        input int rn, input int rd, input int sh, input int rm);
        return {opc, op, 3'(rn), 3'(rd), 2'(sh), 3'(rm)};
    endfunction

    function automatic logic [15:0] enc_imm(input int rn, input logic [7:0] imm);
        return {3'b110, 2'b10, 3'(rn), imm};
    endfunction

    // Applies one instruction to the reference state; returns expected idle latency
    function automatic int ref_step(input logic [15:0] i, input bit commit_rd);
        logic [2:0]  opc;
        logic [1:0]  op;
        int          rn, rd, sh, rm, diff;
        logic [15:0] b, opb, res;
        opc = i[15:13];
        op  = i[12:11];
        rn  = int'(i[10:8]);
        rd  = int'(i[7:5]);
        sh  = int'(i[4:3]);
        rm  = int'(i[2:0]);
        if (opc == 3'b110 && op == 2'b10) begin
            ref_r[rn] = {{8{i[7]}}, i[7:0]};
            return 2;
        end
        b = ref_r[rm];
        case (sh)
            1:       opb = 16'(b * 2);
            2:       opb = b / 16'd2;
            3:       opb = 16'($signed(b) >>> 1);
            default: opb = b;
        endcase
        if (opc == 3'b110 && op == 2'b00) begin
            ref_c = opb;
            if (commit_rd) ref_r[rd] = opb;
            return 5;
        end
        if (opc == 3'b101) begin
            if (op == 2'b01) begin
                diff  = int'($signed(ref_r[rn])) - int'($signed(opb));
                res   = 16'(diff);
                ref_n = res[15];
                ref_z = (res == 16'd0);
                ref_v = (diff > 32767) || (diff < -32768);
                return 4;
            end
            case (op)
                2'b00:   res = ref_r[rn] + opb;
                2'b10:   res = ref_r[rn] & opb;
                default: res = ~opb;
            endcase
            ref_c = res;
            if (commit_rd) ref_r[rd] = res;
            return 5;
        end
        return 1;
    endfunction

    task automatic issue(input logic [15:0] instr);
        @(negedge clk);
        in   = instr;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        s    = 1'b1;
        @(posedge clk);
        #1;
        s = 1'b0;
    endtask

    task automatic wait_idle(output int lat);
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (w === 1'b1) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s     = 1'b0;
        load  = 1'b0;
        in    = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if (w !== 1'b1) $display("FAIL reset_w got %b want 1", w);
        else passed++;
        total++;
        if ({out, N, V, Z} !== {ref_c, ref_n, ref_v, ref_z})
            $display("FAIL reset_state got %h %b%b%b want all X", out, N, V, Z);
        else passed++;
    endtask

    task automatic test_mov_imm();
        logic [15:0] prog [3];
        int lat, exp_lat;
        prog = '{enc_imm(0, 8'd3), enc_imm(1, 8'd2), enc_imm(2, 8'd10)};
        foreach (prog[k]) begin
            issue(prog[k]);
            wait_idle(lat);
            exp_lat = ref_step(prog[k], 1'b1);
            total++;
            if (lat !== exp_lat) $display("FAIL mov_imm_lat[%0d] got %0d want %0d", k, lat, exp_lat);
            else passed++;
            total++;
            if ({out, N, V, Z} !== {ref_c, ref_n, ref_v, ref_z})
                $display("FAIL mov_imm_state[%0d] got %h %b%b%b want X", k, out, N, V, Z);
            else passed++;
        end
    endtask

    task automatic test_mov_reg();
        logic [15:0] prog [3];
        logic [15:0] want [3];
        int lat, exp_lat;
        prog = '{enc(3'b110, 2'b00, 0, 3, 0, 0), enc(3'b110, 2'b00, 0, 4, 1, 2),
                 enc(3'b110, 2'b00, 0, 5, 2, 1)};
        want = '{16'd3, 16'd20, 16'd1};
        foreach (prog[k]) begin
            issue(prog[k]);
            wait_idle(lat);
            exp_lat = ref_step(prog[k], 1'b1);
            total++;
            if (lat !== exp_lat) $display("FAIL mov_reg_lat[%0d] got %0d want %0d", k, lat, exp_lat);
            else passed++;
            total++;
            if (out !== want[k]) $display("FAIL mov_reg_out[%0d] got %h want %h", k, out, want[k]);
            else passed++;
            total++;
            if ({N, V, Z} !== {ref_n, ref_v, ref_z})
                $display("FAIL mov_reg_flags[%0d] got %b%b%b want XXX", k, N, V, Z);
            else passed++;
        end
    endtask

    task automatic test_add();
        logic [15:0] prog [3];
        logic [15:0] want [3];
        int lat, exp_lat;
        prog = '{enc(3'b101, 2'b00, 0, 4, 0, 1), enc(3'b101, 2'b00, 0, 4, 1, 1),
                 enc(3'b101, 2'b00, 0, 4, 2, 1)};
        want = '{16'd5, 16'd7, 16'd4};
        foreach (prog[k]) begin
            issue(prog[k]);
            wait_idle(lat);
            exp_lat = ref_step(prog[k], 1'b1);
            total++;
            if (lat !== exp_lat) $display("FAIL add_lat[%0d] got %0d want %0d", k, lat, exp_lat);
            else passed++;
            total++;
            if (out !== want[k]) $display("FAIL add_out[%0d] got %h want %h", k, out, want[k]);
            else passed++;
        end
    endtask

    task automatic test_cmp();
        logic [15:0] prog [3];
        logic [2:0]  want [3];
        int lat, exp_lat;
        prog = '{enc(3'b101, 2'b01, 0, 0, 0, 0), enc(3'b101, 2'b01, 1, 0, 0, 0),
                 enc(3'b101, 2'b01, 2, 0, 2, 1)};
        want = '{3'b001, 3'b100, 3'b000};
        foreach (prog[k]) begin
            issue(prog[k]);
            wait_idle(lat);
            exp_lat = ref_step(prog[k], 1'b1);
            total++;
            if (lat !== exp_lat) $display("FAIL cmp_lat[%0d] got %0d want %0d", k, lat, exp_lat);
            else passed++;
            total++;
            if (out !== 16'd4) $display("FAIL cmp_out[%0d] got %h want 0004", k, out);
            else passed++;
            total++;
            if ({N, V, Z} !== want[k]) $display("FAIL cmp_flags[%0d] got %b%b%b want %b", k, N, V, Z, want[k]);
            else passed++;
        end
    endtask

    task automatic test_and();
        logic [15:0] prog [2];
        int lat, exp_lat;
        prog = '{enc(3'b101, 2'b10, 0, 4, 0, 1), enc(3'b101, 2'b10, 2, 4, 1, 5)};
        foreach (prog[k]) begin
            issue(prog[k]);
            wait_idle(lat);
            exp_lat = ref_step(prog[k], 1'b1);
            total++;
            if (lat !== exp_lat) $display("FAIL and_lat[%0d] got %0d want %0d", k, lat, exp_lat);
            else passed++;
            total++;
            if (out !== 16'd2) $display("FAIL and_out[%0d] got %h want 0002", k, out);
            else passed++;
            total++;
            if ({N, V, Z} !== 3'b000) $display("FAIL and_flags[%0d] got %b%b%b want 000", k, N, V, Z);
            else passed++;
        end
    endtask

    task automatic test_mvn();
        logic [15:0] prog [3];
        logic [15:0] want [3];
        int lat, exp_lat;
        prog = '{enc(3'b101, 2'b11, 0, 6, 0, 0), enc(3'b101, 2'b11, 0, 6, 1, 0),
                 enc(3'b101, 2'b11, 0, 7, 0, 5)};
        want = '{16'hFFFC, 16'hFFF9, 16'hFFFE};
        foreach (prog[k]) begin
            issue(prog[k]);
            wait_idle(lat);
            exp_lat = ref_step(prog[k], 1'b1);
            total++;
            if (lat !== exp_lat) $display("FAIL mvn_lat[%0d] got %0d want %0d", k, lat, exp_lat);
            else passed++;
            total++;
            if (out !== want[k]) $display("FAIL mvn_out[%0d] got %h want %h", k, out, want[k]);
            else passed++;
            total++;
            if ({N, V, Z} !== 3'b000) $display("FAIL mvn_flags[%0d] got %b%b%b want 000", k, N, V, Z);
            else passed++;
        end
    endtask

    // load and s asserted while busy must not disturb the running instruction
    task automatic test_busy_ignore();
        logic [15:0] instr;
        int lat, exp_lat;
        instr = enc(3'b101, 2'b00, 2, 3, 0, 0);
        issue(instr);
        in   = enc(3'b101, 2'b11, 1, 6, 0, 1);
        load = 1'b1;
        s    = 1'b1;
        lat  = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (e == 3) begin
                load = 1'b0;
                s    = 1'b0;
            end
            if (w === 1'b1) begin
                lat = e;
                break;
            end
        end
        exp_lat = ref_step(instr, 1'b1);
        total++;
        if (lat !== exp_lat) $display("FAIL busy_lat got %0d want %0d", lat, exp_lat);
        else passed++;
        total++;
        if (out !== ref_c) $display("FAIL busy_out got %h want %h", out, ref_c);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (w !== 1'b1) $display("FAIL busy_stays_idle got %b want 1", w);
        else passed++;
    endtask

    task automatic test_invalid();
        logic [15:0] prog [3];
        int lat, exp_lat;
        prog = '{16'h0123, enc(3'b110, 2'b01, 1, 2, 0, 3), enc(3'b111, 2'b00, 4, 4, 0, 4)};
        foreach (prog[k]) begin
            issue(prog[k]);
            wait_idle(lat);
            exp_lat = ref_step(prog[k], 1'b1);
            total++;
            if (lat !== exp_lat) $display("FAIL invalid_lat[%0d] got %0d want %0d", k, lat, exp_lat);
            else passed++;
            total++;
            if ({out, N, V, Z} !== {ref_c, ref_n, ref_v, ref_z})
                $display("FAIL invalid_state[%0d] got %h %b%b%b want %h %b%b%b", k, out, N, V, Z,
                         ref_c, ref_n, ref_v, ref_z);
            else passed++;
        end
    endtask

    // Reset at the Exec edge (nothing lands) and at the WriteReg edge (C lands, Rd does not)
    task automatic test_reset_abort(input int abort_edge);
        logic [15:0] instr, probe;
        int lat, exp_lat;
        instr = enc(3'b101, 2'b00, 1, 6, 0, 2);
        issue(instr);
        for (int e = 1; e < abort_edge; e++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        if (abort_edge == 5) exp_lat = ref_step(instr, 1'b0);
        total++;
        if (w !== 1'b1) $display("FAIL abort%0d_w got %b want 1", abort_edge, w);
        else passed++;
        total++;
        if (out !== ref_c) $display("FAIL abort%0d_out got %h want %h", abort_edge, out, ref_c);
        else passed++;
        probe = enc(3'b110, 2'b00, 0, 7, 0, 6);
        issue(probe);
        wait_idle(lat);
        exp_lat = ref_step(probe, 1'b1);
        total++;
        if (lat !== exp_lat || out !== ref_c)
            $display("FAIL abort%0d_rd got %h lat %0d want %h lat %0d", abort_edge, out, lat, ref_c, exp_lat);
        else passed++;
    endtask

    task automatic test_random();
        logic [15:0] instr;
        logic [2:0]  bad_opc [6];
        int lat, exp_lat, kind;
        bad_opc = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
        for (int r = 0; r < 8; r++) begin
            instr = enc_imm(r, 8'($urandom));
            issue(instr);
            wait_idle(lat);
            exp_lat = ref_step(instr, 1'b1);
            total++;
            if (lat !== exp_lat) $display("FAIL rnd_init_lat[%0d] got %0d want %0d", r, lat, exp_lat);
            else passed++;
        end
        for (int k = 0; k < 60; k++) begin
            kind  = int'($urandom_range(0, 6));
            instr = 16'($urandom);
            case (kind)
                0: instr[15:11] = 5'b11010;
                1: instr[15:11] = 5'b11000;
                2, 3, 4, 5: instr[15:13] = 3'b101;
                default: instr[15:13] = bad_opc[$urandom_range(0, 5)];
            endcase
            issue(instr);
            wait_idle(lat);
            exp_lat = ref_step(instr, 1'b1);
            total++;
            if (lat !== exp_lat) $display("FAIL rnd_lat[%0d] instr %h got %0d want %0d", k, instr, lat, exp_lat);
            else passed++;
            total++;
            if (out !== ref_c) $display("FAIL rnd_out[%0d] instr %h got %h want %h", k, instr, out, ref_c);
            else passed++;
            total++;
            if ({N, V, Z} !== {ref_n, ref_v, ref_z})
                $display("FAIL rnd_flags[%0d] instr %h got %b%b%b want %b%b%b", k, instr, N, V, Z,
                         ref_n, ref_v, ref_z);
            else passed++;
        end
    endtask

    initial begin
        foreach (ref_r[k]) ref_r[k] = 'x;
        ref_c = 'x;
        ref_n = 1'bx;
        ref_v = 1'bx;
        ref_z = 1'bx;
        test_reset();
        test_mov_imm();
        test_mov_reg();
        test_add();
        test_cmp();
        test_and();
        test_mvn();
        test_busy_ignore();
        test_invalid();
        test_reset_abort(4);
        test_reset_abort(5);
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/simple_risc_cpu.md
Name: simple_risc_cpu

Overview:
- Multi-cycle 16-bit CPU core: eight 16-bit general registers R0–R7, a barrel shifter, an ALU, a result register C, a status register (N, V, Z), an instruction register (IR) and a control FSM.
- Instructions are presented on `in`, captured with `load`, started with `s`.
- `w` reports idle. `out` exposes register C.
- Top of the execution core; instruction memory and PC are added later.

Parameters:
- none (word width fixed at 16, register count fixed at 8)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, no other clocks
- s  input  1  start: begins execution of the instruction held in IR
- load  input  1  capture `in` into IR
- in  input  16  instruction word
- out  output  16  contents of result register C
- N  output  1  status: negative
- V  output  1  status: signed overflow
- Z  output  1  status: zero
- w  output  1  1 while the FSM is in Wait (idle)

Behaviour:
- Reset (sampled at posedge):
  - FSM goes to Wait, so w=1 from the following cycle.
  - Reset touches only FSM state. IR, R0–R7, C and status are not reset, so out/N/V/Z stay X until first written.
- IR loads `in` at posedge when load=1 and FSM is in Wait. load is ignored while w=0.
- s is sampled only in Wait. s=1 moves the FSM to Decode; s while busy is ignored.
- Encoding: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm, [7:0] imm8.
- Shifter on the Rm operand:
  - sh=00: unchanged
  - sh=01: LSL 1, shift in 0
  - sh=10: LSR 1, shift in 0
  - sh=11: ASR 1, bit 15 preserved
- ALU ops: 00 add, 01 subtract, 10 AND, 11 NOT B. All 16-bit wrap-around.
- Instructions:
  - 110_10 MOV Rn,#imm8: Rn <= sign-extend(imm8). C and status unchanged.
  - 110_00 MOV Rd,Rm{,sh}: C <= 0 + sh(Rm); Rd <= C.
  - 101_00 ADD: C <= Rn + sh(Rm); Rd <= C.
  - 101_01 CMP: status <= flags of Rn − sh(Rm). C and registers unchanged.
  - 101_10 AND: C <= Rn & sh(Rm); Rd <= C.
  - 101_11 MVN: C <= ~sh(Rm); Rd <= C.
  - Other encodings: Decode returns to Wait with no state change.
- Status is written only by CMP:
  - N = result[15]
  - Z = (result == 0)
  - V = signed overflow of the subtraction: operand signs differ AND result sign ≠ Rn sign.
- FSM states: Wait, Decode, WriteImm, GetA, GetB, Exec, WriteReg.
  - Wait –s→ Decode.
  - Decode → WriteImm (MOV imm), else GetA.
  - WriteImm → Wait.
  - GetA (A <= Rn; MOV/MVN select A=0) → GetB (B <= Rm) → Exec (C or status load).
  - Exec → WriteReg (Rd <= C) → Wait. CMP goes Exec → Wait directly.
- Latency, counted from the posedge that samples s=1 (edge 0); w=1 again after:
  - MOV imm: edge 2
  - CMP: edge 4
  - others: edge 5
- out updates at the Exec edge.
- Register reads are combinational from the register file. Writes occur at posedge.
- Reading a register never written yields X (no initialisation).
- Reset mid-instruction: abort at that edge. Writes scheduled for later states do not occur; edges already taken keep their effect.

Decomposition:
- Shared package `srm_pkg`:
  - opcode/op constants (OPC_MOV=3'b110, OPC_ALU=3'b101)
  - ALU op codes
  - shift codes
  - FSM state enum
- One natural sub-module, `srm_datapath`: register file, shifter, ALU, A/B/C and status registers. The FSM plus IR stay in the top module.

Test Plan:
1. Reset, release, run MOV R0,#3; MOV R1,#2; MOV R2,#10 → w returns to 1 after each; out, N, V, Z remain X.
2. MOV R3,R0 → out=3. MOV R4,R2,LSL#1 → out=20. MOV R5,R1,LSR#1 → out=1. N/V/Z still X.
3. ADD R4,R0,R1 → 5. With LSL#1 → 7. With LSR#1 → 4.
4. CMP R0,R0 → out=4, N=0 V=0 Z=1. CMP R1,R0 → N=1 V=0 Z=0. CMP R2,R1,LSR#1 → N=0 V=0 Z=0.
5. AND R4,R0,R1 → out=2, flags unchanged (0,0,0). AND R4,R2,R5,LSL#1 → 2.
6. MVN R6,R0 → 16'hFFFC. MVN R6,R0,LSL#1 → 16'hFFF9. MVN R7,R5 → 16'hFFFE. Flags stay 0,0,0.
